// File: rtl/interp_sched.sv
// Interpolator scheduler: prescales the master clock to the output sample rate and
// sequences the accumulate / divide / output steps of one interpolated sample.
// Optional feature: define INTERP_SCHED_TIMEOUT_EN to bound the wait for the divider
// (TIMEOUT cycles), after which the sample is emitted anyway and timeout_err is set.
// TIMEOUT must be at least 1 when the feature is enabled.
module interp_sched #(
    parameter int unsigned CLKDIV  = 256,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] nfreq_in,
    input  logic       div_done,
    output logic       en48k,
    output logic       endataout,
    output logic       endatain,
    output logic       div_start,
    output logic [3:0] nfreq_eff,
    output logic [3:0] phase,
    output logic       dout_valid,
    output logic       overrun,
    output logic       timeout_err
);

    localparam int unsigned PW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
    localparam logic [PW-1:0] PLAST = PW'(CLKDIV - 1);
    localparam int unsigned TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

`ifdef INTERP_SCHED_TIMEOUT_EN
    localparam bit TIMEOUT_ON = 1'b1;
`else
    localparam bit TIMEOUT_ON = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, ACC, DIV, WAIT, OUT} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   count_q;
    logic [TW-1:0]   wait_cnt_q;
    logic            timeout_hit;
    logic            overrun_q;
    logic            timeout_err_q;

    // Requested factor 0 makes no sense as a divisor; cap at the datapath's maximum of 10.
    function automatic logic [3:0] clamp_nfreq(input logic [3:0] n);
        if (n == 4'd0) begin
            return 4'd1;
        end else if (n > 4'd10) begin
            return 4'd10;
        end else begin
            return n;
        end
    endfunction

    // Output-rate prescaler, free running 0..CLKDIV-1.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else if (count_q == PLAST) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + 1'b1;
        end
    end

    assign en48k = (count_q == PLAST);

    // Cycles spent in WAIT; only consulted when the timeout feature is built in.
    always_ff @(posedge clock) begin
        if (reset || state_q != WAIT) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
        end
    end

    // A real div_done on the last allowed cycle wins over the timeout.
    assign timeout_hit = TIMEOUT_ON && (state_q == WAIT) && !div_done && (wait_cnt_q == TLAST);

    // Sequence state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; div_done is only meaningful in WAIT.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (en48k) state_d = ACC;
            ACC:     state_d = DIV;
            DIV:     state_d = WAIT;
            WAIT:    if (div_done || timeout_hit) state_d = OUT;
            OUT:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign endataout  = (state_q == ACC);
    assign div_start  = (state_q == DIV);
    assign dout_valid = (state_q == OUT);
    assign endatain   = (state_q == ACC) && (phase == 4'd0);

    // Sub-sample phase; the factor is only re-sampled on wrap so a sequence is never torn.
    always_ff @(posedge clock) begin
        if (reset) begin
            phase     <= 4'd0;
            nfreq_eff <= clamp_nfreq(nfreq_in);
        end else if (state_q == ACC) begin
            if (phase == nfreq_eff - 4'd1) begin
                phase     <= 4'd0;
                nfreq_eff <= clamp_nfreq(nfreq_in);
            end else begin
                phase <= phase + 4'd1;
            end
        end
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            overrun_q     <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            if (en48k && state_q != IDLE) overrun_q <= 1'b1;
            if (timeout_hit) timeout_err_q <= 1'b1;
        end
    end

    assign overrun     = overrun_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: doc/interp_sched.md
INTERP_SCHED -- requirements
Module: interp_sched

Interface
REQ-001 SHALL have parameter CLKDIV, default 256, clock cycles per output sample period (48 kHz at 12.288 MHz).
REQ-002 SHALL have parameter TIMEOUT, default 64, maximum cycles spent waiting for divider completion (used only with the timeout feature).
REQ-003 SHALL have port clock  input  1  master clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port nfreq_in  input  4  requested interpolation factor, unsigned.
REQ-006 SHALL have port div_done  input  1  one-cycle pulse from the sequential divider marking quotient ready.
REQ-007 SHALL have port en48k  output  1  one-cycle output-rate tick.
REQ-008 SHALL have port endataout  output  1  one-cycle integrator/output enable to the interpolator datapath.
REQ-009 SHALL have port endatain  output  1  one-cycle input-sample enable to the differentiator.
REQ-010 SHALL have port div_start  output  1  one-cycle divider start pulse.
REQ-011 SHALL have port nfreq_eff  output  4  latched, clamped interpolation factor (divisor).
REQ-012 SHALL have port phase  output  4  current sub-sample index, 0..nfreq_eff-1.
REQ-013 SHALL have port dout_valid  output  1  one-cycle pulse, interpolated sample valid.
REQ-014 SHALL have port overrun  output  1  sticky, a tick arrived while the sequence was busy.
REQ-015 SHALL have port timeout_err  output  1  sticky, divider did not complete in time.

Function
REQ-016 Prescaler SHALL count 0..CLKDIV-1 and wrap; en48k SHALL be high exactly in the cycle where count equals CLKDIV-1.
REQ-017 FSM states SHALL be IDLE, ACC, DIV, WAIT, OUT.
REQ-018 IDLE SHALL go to ACC in the cycle after en48k; ACC SHALL go to DIV; DIV SHALL go to WAIT; WAIT SHALL go to OUT in the cycle after div_done; OUT SHALL go to IDLE.
REQ-019 endataout SHALL be high only in ACC; div_start SHALL be high only in DIV; dout_valid SHALL be high only in OUT.
REQ-020 Latency: for en48k at cycle T, endataout at T+1, div_start at T+2, and dout_valid one cycle after the div_done received in WAIT.
REQ-021 endatain SHALL be high in ACC exactly when phase equals 0.
REQ-022 phase SHALL increment when leaving ACC and SHALL wrap to 0 after reaching nfreq_eff-1.
REQ-023 nfreq_eff SHALL load from nfreq_in only when phase wraps to 0; nfreq_in values 0 SHALL load as 1 and values above 10 SHALL load as 10.
REQ-024 A change of nfreq_in mid-sequence SHALL NOT affect nfreq_eff until the next wrap.
REQ-025 An en48k arriving while the FSM is not in IDLE SHALL be dropped and SHALL set overrun.
REQ-026 div_done outside WAIT SHALL be ignored.
REQ-027 With nfreq_eff equal to 1, endatain SHALL accompany every endataout.

Reset
REQ-028 Reset SHALL force prescaler 0, FSM IDLE, phase 0, and all pulse outputs, overrun and timeout_err to 0.
REQ-029 Reset SHALL load nfreq_eff from clamped nfreq_in.
REQ-030 Reset asserted mid-sequence SHALL abandon the sequence without emitting dout_valid.
REQ-031 The sticky flags overrun and timeout_err SHALL be cleared only by reset.

Configuration
REQ-032 With macro INTERP_SCHED_TIMEOUT_EN defined, a cycle counter SHALL run in WAIT; after TIMEOUT cycles without div_done the FSM SHALL go to OUT, pulse dout_valid, and set timeout_err.
REQ-033 Without INTERP_SCHED_TIMEOUT_EN, WAIT SHALL hold indefinitely and timeout_err SHALL be constant 0.

Verification
REQ-034 CLKDIV=8, nfreq_in=4, div_done 3 cycles after div_start -> en48k every 8 cycles; endatain on every 4th endataout; phase 0,1,2,3,0; dout_valid once per period.
REQ-035 nfreq_in=0 then 15 -> nfreq_eff=1 (endatain every period), then 10 after the next wrap.
REQ-036 nfreq_in changed 4->6 at phase 2 -> remaining phases 3,0 under factor 4, then six-phase cycle.
REQ-037 div_done withheld past the next en48k -> overrun=1, the tick is dropped, no extra endataout; overrun stays 1 until reset.
REQ-038 TIMEOUT_EN, TIMEOUT=5, div_done never -> dout_valid 5 cycles after entering WAIT, timeout_err=1; without the macro the FSM stays in WAIT.
REQ-039 Reset pulsed in WAIT -> no dout_valid; phase=0; restart aligned to prescaler 0.
